dmu_sii_req_issuer: RTL

DMU-side inbound request issuer that drives the DMU→SII interface. It accepts fully buffered requests from the DMU core: DMA read, DMA write, Mondo interrupt, and PIO read completion. It serializes each request onto the SII header/payload bus with per-16-bit parity. It gates DMA-class requests on SII credits and tracks outstanding tags, which are returned through `sii_dmu_wrack_vld`/`sii_dmu_wrack_tag`.

---
 rtl/dmu_sii_req_issuer_if.sv | 39 +++
 rtl/dmu_sii_req_issuer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dmu_sii_req_issuer_if.sv
// DMU -> SII request issuer bus: core-side request handshake, SII
// header/payload bus and the SII write-ack credit return.
interface dmu_sii_req_issuer_if;
    logic         req_vld;
    logic         req_rdy;
    logic [1:0]   req_type;
    logic [127:0] req_hdr;
    logic [511:0] req_pld;
    logic [63:0]  req_be;

    logic         dmu_sii_hdr_vld;
    logic         dmu_sii_datareq;
    logic         dmu_sii_datareq16;
    logic         dmu_sii_reqbypass;
    logic [127:0] dmu_sii_data;
    logic [7:0]   dmu_sii_parity;
    logic [15:0]  dmu_sii_be;

    logic         sii_dmu_wrack_vld;
    logic [3:0]   sii_dmu_wrack_tag;

    // Issuer side
    modport slave (
        input  req_vld, req_type, req_hdr, req_pld, req_be,
        input  sii_dmu_wrack_vld, sii_dmu_wrack_tag,
        output req_rdy,
        output dmu_sii_hdr_vld, dmu_sii_datareq, dmu_sii_datareq16,
        output dmu_sii_reqbypass, dmu_sii_data, dmu_sii_parity, dmu_sii_be
    );

    // Core / SII side
    modport master (
        output req_vld, req_type, req_hdr, req_pld, req_be,
        output sii_dmu_wrack_vld, sii_dmu_wrack_tag,
        input  req_rdy,
        input  dmu_sii_hdr_vld, dmu_sii_datareq, dmu_sii_datareq16,
        input  dmu_sii_reqbypass, dmu_sii_data, dmu_sii_parity, dmu_sii_be
    );
endinterface

// File: rtl/dmu_sii_req_issuer.sv
// DMU -> SII inbound request issuer. Serialises buffered DMA read/write,
// Mondo and PIO-completion requests onto the SII header/payload bus and
// gates DMA-class requests on SII credits and per-tag outstanding state.
module dmu_sii_req_issuer #(
    parameter int unsigned CREDITS = 16
) (
    input  logic                 iol2clk,
    input  logic                 rst,
    dmu_sii_req_issuer_if.slave  bus,
    output logic [4:0]           credit_cnt,
    output logic                 credit_err
);
    typedef enum logic [1:0] {IDLE, HDR, PLD} state_t;
    typedef enum logic [1:0] {T_RD = 2'b00, T_WR = 2'b01, T_MONDO = 2'b10, T_PIO = 2'b11} req_t;

    localparam logic [4:0] CRED_MAX = 5'(CREDITS);

    state_t       state_q, state_d;
    logic [1:0]   beat_q, beat_d;
    req_t         type_q;
    logic [127:0] hdr_q;
    logic [511:0] pld_q;
    logic [63:0]  be_q;
    logic [15:0]  outstanding_q, outstanding_d;
    logic [4:0]   credit_d;
    logic         err_set;
    logic         free, accept, dma_acc, wr_hit, overflow;
    logic [1:0]   last_beat;
    logic [3:0]   tag;
    logic [127:0] data;

    // Interface availability and request acceptance
    always_comb begin
        last_beat   = (type_q == T_WR) ? 2'd3 : 2'd0;
        free        = (state_q == IDLE) ||
                      (state_q == HDR && type_q == T_RD) ||
                      (state_q == PLD && beat_q == last_beat);
        tag         = bus.req_hdr[67:64];
        bus.req_rdy = !rst && free &&
                      (bus.req_type == T_PIO || (credit_cnt != '0 && !outstanding_q[tag]));
        accept      = bus.req_vld && bus.req_rdy;
        dma_acc     = accept && (bus.req_type != T_PIO);
    end

    // State register and beat counter
    always_ff @(posedge iol2clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: if (accept) state_d = HDR;
            HDR: begin
                beat_d = '0;
                if (type_q == T_RD) state_d = accept ? HDR : IDLE;
                else                state_d = PLD;
            end
            PLD: begin
                if (beat_q == last_beat) state_d = accept ? HDR : IDLE;
                else                     beat_d  = beat_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture request fields at accept so the core may move on
    always_ff @(posedge iol2clk) begin
        if (rst) begin
            type_q <= T_RD;
            hdr_q  <= '0;
            pld_q  <= '0;
            be_q   <= '0;
        end else if (accept) begin
            type_q <= req_t'(bus.req_type);
            hdr_q  <= bus.req_hdr;
            pld_q  <= bus.req_pld;
            be_q   <= bus.req_be;
        end
    end

    // Credit / outstanding-tag bookkeeping; a same-tag set beats the clear
    always_comb begin
        wr_hit        = bus.sii_dmu_wrack_vld && outstanding_q[bus.sii_dmu_wrack_tag];
        overflow      = wr_hit && !dma_acc && (credit_cnt >= CRED_MAX);
        err_set       = (bus.sii_dmu_wrack_vld && !wr_hit) || overflow;
        outstanding_d = outstanding_q;
        if (wr_hit)  outstanding_d[bus.sii_dmu_wrack_tag] = 1'b0;
        if (dma_acc) outstanding_d[tag] = 1'b1;
        credit_d = credit_cnt;
        case ({wr_hit && !overflow, dma_acc})
            2'b10:   credit_d = credit_cnt + 5'd1;
            2'b01:   credit_d = credit_cnt - 5'd1;
            default: credit_d = credit_cnt;
        endcase
    end

    // Credit registers and sticky error
    always_ff @(posedge iol2clk) begin
        if (rst) begin
            credit_cnt    <= CRED_MAX;
            outstanding_q <= '0;
            credit_err    <= 1'b0;
        end else begin
            credit_cnt    <= credit_d;
            outstanding_q <= outstanding_d;
            if (err_set) credit_err <= 1'b1;
        end
    end

    // SII bus drive: header cycle, payload beats, zero when idle
    always_comb begin
        bus.dmu_sii_hdr_vld   = 1'b0;
        bus.dmu_sii_datareq   = 1'b0;
        bus.dmu_sii_datareq16 = 1'b0;
        bus.dmu_sii_reqbypass = 1'b0;
        bus.dmu_sii_be        = '0;
        data                  = '0;
        case (state_q)
            HDR: begin
                bus.dmu_sii_hdr_vld   = 1'b1;
                data                  = hdr_q;
                bus.dmu_sii_datareq   = (type_q != T_RD);
                bus.dmu_sii_datareq16 = (type_q == T_MONDO) || (type_q == T_PIO);
                bus.dmu_sii_reqbypass = (type_q == T_PIO);
            end
            PLD: begin
                data           = pld_q[{beat_q, 7'd0} +: 128];
                bus.dmu_sii_be = (type_q == T_WR) ? be_q[{beat_q, 4'd0} +: 16] : '1;
            end
            default: ;
        endcase
        bus.dmu_sii_data = data;
        for (int unsigned i = 0; i < 8; i++)
            bus.dmu_sii_parity[i] = ^data[16*i +: 16];
    end
endmodule
